// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule: word/key types, forward S-box,
// round constants and the SubWord helper.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] key_t;

    // Row r of the table holds S-box entries 16r..16r+15, entry 0 in the MSBs.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon_of(input int idx);
        logic [7:0] v;
        case (idx)
            0:       v = 8'h01;
            1:       v = 8'h02;
            2:       v = 8'h04;
            3:       v = 8'h08;
            4:       v = 8'h10;
            5:       v = 8'h20;
            6:       v = 8'h40;
            7:       v = 8'h80;
            8:       v = 8'h1b;
            9:       v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/key_round_stage.sv
// One AES-128 key-schedule round, registered. Build option KEYEXP_CLR_ON_INVALID_EN
// zeroes the slice on invalid input instead of holding it.
module key_round_stage
    import aes_pkg::*;
#(
    parameter logic [7:0] RCON = 8'h01
) (
    input  logic clk,
    input  logic reset,
    input  key_t key_in,
    input  logic valid_in,
    output key_t key_out,
    output logic valid_out
);

    word_t w_rot;
    word_t w_t;
    word_t w_n0;
    word_t w_n1;
    word_t w_n2;
    word_t w_n3;
    key_t  r_key;
    logic  r_valid;

    // Next round key from the incoming key words w0..w3.
    always_comb begin
        w_rot = {key_in[23:0], key_in[31:24]};
        w_t   = sub_word(w_rot) ^ {RCON, 24'h000000};
        w_n0  = key_in[127:96] ^ w_t;
        w_n1  = key_in[95:64]  ^ w_n0;
        w_n2  = key_in[63:32]  ^ w_n1;
        w_n3  = key_in[31:0]   ^ w_n2;
    end

    // Stage register; valid always follows the incoming valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= valid_in;
`ifdef KEYEXP_CLR_ON_INVALID_EN
            r_key   <= valid_in ? {w_n0, w_n1, w_n2, w_n3} : 128'h0;
`else
            if (valid_in) begin
                r_key <= {w_n0, w_n1, w_n2, w_n3};
            end
`endif
        end
    end

    assign key_out   = r_key;
    assign valid_out = r_valid;

endmodule

// File: rtl/key_expantion.sv
// Pipelined AES-128 key expansion: ten chained round stages, one key per clock.
// Optional macro KEYEXP_CLR_ON_INVALID_EN clears stage slices on invalid input.
module key_expantion
    import aes_pkg::*;
#(
    parameter int KEY_LEN       = 128,
    parameter int NUMS_OF_ROUND = 10
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [KEY_LEN-1:0]                Secret_key,
    input  logic                              valid_in,
    output logic [NUMS_OF_ROUND*KEY_LEN-1:0]  key_expan,
    output logic [NUMS_OF_ROUND-1:0]          valid_out
);

    key_t                 w_key_chain [NUMS_OF_ROUND+1];
    logic [NUMS_OF_ROUND:0] w_valid_chain;

    assign w_key_chain[0]   = Secret_key;
    assign w_valid_chain[0] = valid_in;

    for (genvar g = 0; g < NUMS_OF_ROUND; g++) begin : g_stage
        key_round_stage #(
            .RCON (rcon_of(g))
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .key_in    (w_key_chain[g]),
            .valid_in  (w_valid_chain[g]),
            .key_out   (w_key_chain[g+1]),
            .valid_out (w_valid_chain[g+1])
        );

        assign key_expan[g*KEY_LEN +: KEY_LEN] = w_key_chain[g+1];
        assign valid_out[g]                    = w_valid_chain[g+1];
    end

endmodule

// File: tb/tb_key_expantion.sv
// Directed bench for key_expantion: FIPS-197 vectors, valid walk, key streaming,
// invalid drop-out and asynchronous reset. Reference S-box is derived from GF(2^8).
module tb_key_expantion;

    logic          clk;
    logic          reset;
    logic [127:0]  secret_key;
    logic          valid_in;
    logic [1279:0] key_expan;
    logic [9:0]    valid_out;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb [256];

    key_expantion #(.KEY_LEN(128), .NUMS_OF_ROUND(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .Secret_key (secret_key),
        .valid_in   (valid_in),
        .key_expan  (key_expan),
        .valid_out  (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        int           slice;
        logic [127:0] exp;
    } vec_t;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [127:0] model_key(input logic [127:0] k, input int slice);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc = 8'h01;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        for (int r = 0; r <= slice; r++) begin
            t  = {sb[w3[23:16]] ^ rc, sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]};
            w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
            rc = gmul(rc, 8'h02);
        end
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] dut_slice(input int i);
        return key_expan[i*128 +: 128];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

    initial begin
        vec_t         vecs [6];
        logic [127:0] hist [10];
        logic [7:0]   inv;
        logic [9:0]   mask;
        logic [127:0] cur;

        // Reference S-box: multiplicative inverse followed by the affine map.
        for (int v = 0; v < 256; v++) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(v));
            sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        vecs[0] = '{KEY_A, 0, 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[1] = '{KEY_A, 1, 128'hf2c295f27a96b9435935807a7359f67f};
        vecs[2] = '{KEY_A, 2, 128'h3d80477d4716fe3e1e237e446d7a883b};
        vecs[3] = '{KEY_A, 9, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[4] = '{KEY_B, 9, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[5] = '{KEY_B, 0, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe};

        reset      = 1'b1;
        secret_key = KEY_A;
        valid_in   = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 10; i++) check($sformatf("reset_slice%0d", i), dut_slice(i), 128'h0);
        check("reset_valid", {118'h0, valid_out}, 128'h0);

        reset = 1'b0;
        for (int v = 0; v < 6; v++) begin
            secret_key = vecs[v].key;
            valid_in   = 1'b1;
            repeat (10) step();
            check($sformatf("vec%0d_slice%0d", v, vecs[v].slice), dut_slice(vecs[v].slice), vecs[v].exp);
            check($sformatf("vec%0d_valid", v), {118'h0, valid_out}, {118'h0, 10'h3ff});
        end
        for (int i = 0; i < 10; i++)
            check($sformatf("keyB_model_slice%0d", i), dut_slice(i), model_key(KEY_B, i));

        // Single-cycle valid pulse walks through valid_out.
        valid_in = 1'b0;
        repeat (10) step();
        check("walk_idle", {118'h0, valid_out}, 128'h0);
        valid_in = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            step();
            valid_in = 1'b0;
            mask = (k < 10) ? (10'h001 << k) : 10'h000;
            check($sformatf("walk_step%0d", k), {118'h0, valid_out}, {118'h0, mask});
        end

        // Alternating keys streamed back to back.
        valid_in = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cur        = (c % 2 == 0) ? KEY_A : KEY_B;
            secret_key = cur;
            step();
            for (int i = 9; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = cur;
            for (int i = 0; i < 10 && i <= c; i++)
                check($sformatf("stream_c%0d_slice%0d", c, i), dut_slice(i), model_key(hist[i], i));
            mask = (c >= 9) ? 10'h3ff : ((10'h001 << (c + 1)) - 10'h001);
            check($sformatf("stream_c%0d_valid", c), {118'h0, valid_out}, {118'h0, mask});
        end

        // One key then valid drops: slices hold (or clear), valid bits fall.
        secret_key = KEY_A;
        valid_in   = 1'b1;
        step();
        valid_in   = 1'b0;
        secret_key = KEY_B;
        repeat (11) step();
        check("drop_valid", {118'h0, valid_out}, 128'h0);
        for (int i = 0; i < 10; i++) begin
`ifdef KEYEXP_CLR_ON_INVALID_EN
            check($sformatf("drop_slice%0d", i), dut_slice(i), 128'h0);
`else
            check($sformatf("drop_slice%0d", i), dut_slice(i), model_key(KEY_A, i));
`endif
        end

        // Asynchronous reset in the middle of a stream.
        valid_in   = 1'b1;
        secret_key = KEY_B;
        repeat (4) step();
        check("pre_reset_slice0", dut_slice(0), model_key(KEY_B, 0));
        reset = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) check($sformatf("async_reset_slice%0d", i), dut_slice(i), 128'h0);
        check("async_reset_valid", {118'h0, valid_out}, 128'h0);
        step();
        reset    = 1'b0;
        valid_in = 1'b0;
        step();
        check("post_reset_valid", {118'h0, valid_out}, 128'h0);
        check("post_reset_slice0", dut_slice(0), 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
